alu_resp: RTL

ALU_RESP -- requirements
Module: alu_resp

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_seq.sv | 68 ++++++
 rtl/alu_resp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared mode encodings, FSM state type and default width for the ALU response block.
// ALU_RESP_MUL_EN adds the CALC state used by the sequential multiplier.
package alu_pkg;

  localparam int ALU_W_DEFAULT = 4;

  localparam logic [3:0] MODE_ADD = 4'b0000;
  localparam logic [3:0] MODE_SUB = 4'b0001;
  localparam logic [3:0] MODE_AND = 4'b0010;
  localparam logic [3:0] MODE_OR  = 4'b0011;
  localparam logic [3:0] MODE_XOR = 4'b0100;
  localparam logic [3:0] MODE_MUL = 4'b0101;
  localparam logic [3:0] MODE_SHL = 4'b0110;
  localparam logic [3:0] MODE_SHR = 4'b0111;

`ifdef ALU_RESP_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: start loads operands, then one partial product per cycle
// for W cycles; done pulses in the final iteration with prod valid alongside it.
module alu_mul_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int RW = 2 * W;
  localparam int CW = (W < 2) ? 1 : $clog2(W + 1);

  logic [RW-1:0] mcand_q, mcand_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [RW-1:0] step_acc;

  // prod is the accumulator after this cycle's partial product, so the top can
  // register it on the same edge the last iteration completes.
  assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == CW'(W - 1));
  assign prod     = step_acc;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = RW'(a);
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_resp.sv
// Valid/ready ALU with a single-entry registered result and a completed-result counter.
// Define ALU_RESP_MUL_EN to enable the multi-cycle MUL mode via alu_mul_seq.
module alu_resp
  import alu_pkg::*;
#(
  parameter int W = ALU_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in1,
  input  logic [W-1:0]   in2,
  input  logic [3:0]     alu_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out,
  output logic           err,
  output logic [7:0]     op_cnt
);

  localparam int RW = 2 * W;

  state_t        state_q, state_d;
  logic [RW-1:0] out_q, out_d;
  logic          err_q, err_d;
  logic [7:0]    op_cnt_q, op_cnt_d;

  logic          accept, drain;
  logic [RW-1:0] a_ext, b_ext, alu_res;
  logic          alu_ill, is_mul, shamt_big;

  // Ready is also offered in a draining DONE so a new request can overlap the handshake.
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out       = out_q;
  assign err       = err_q;
  assign op_cnt    = op_cnt_q;

  assign a_ext     = RW'(in1);
  assign b_ext     = RW'(in2);
  assign shamt_big = (32'(in2) >= 32'(RW));

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (alu_mode)
      MODE_ADD: alu_res = a_ext + b_ext;
      MODE_SUB: alu_res = a_ext - b_ext;
      MODE_AND: alu_res = a_ext & b_ext;
      MODE_OR:  alu_res = a_ext | b_ext;
      MODE_XOR: alu_res = a_ext ^ b_ext;
      MODE_SHL: alu_res = shamt_big ? '0 : (a_ext << in2);
      MODE_SHR: alu_res = shamt_big ? '0 : (a_ext >> in2);
`ifdef ALU_RESP_MUL_EN
      MODE_MUL: is_mul  = 1'b1;
`endif
      default:  alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_RESP_MUL_EN
  logic          mul_start, mul_done;
  logic [RW-1:0] mul_prod;

  assign mul_start = accept && is_mul;

  alu_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (in1),
    .b     (in2),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    err_d    = err_q;
    op_cnt_d = op_cnt_q;
    if (drain) begin
      op_cnt_d = op_cnt_q + 8'd1;
      state_d  = IDLE;
    end
    // accept only fires in IDLE or a draining DONE, so it overrides the drain above
    if (accept) begin
`ifdef ALU_RESP_MUL_EN
      if (is_mul) begin
        state_d = CALC;
      end else begin
        state_d = DONE;
        out_d   = alu_res;
        err_d   = alu_ill;
      end
`else
      state_d = DONE;
      out_d   = alu_res;
      err_d   = alu_ill;
`endif
    end
`ifdef ALU_RESP_MUL_EN
    if ((state_q == CALC) && mul_done) begin
      state_d = DONE;
      out_d   = mul_prod;
      err_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      err_q    <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      err_q    <= err_d;
      op_cnt_q <= op_cnt_d;
    end
  end

endmodule
